// File: rtl/pa_spsram_clr_param.sv
// Parametrised single-port SRAM with active-low macro protocol, hardware clear engine,
// group write masking and an optional output register stage.
module pa_spsram_clr_param #(
  parameter int unsigned           ADDR_WIDTH = 7,
  parameter int unsigned           DATA_WIDTH = 43,
  parameter int unsigned           WE_WIDTH   = 43,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
  parameter bit                    CLR_ON_RST = 1'b1,
  parameter bit                    OUT_REG    = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  BUSY
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned GrpW  = DATA_WIDTH / WE_WIDTH;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem [Depth];
  logic [DATA_WIDTH-1:0]   bit_mask;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic                    last;
  logic                    clearing;
  logic                    wr_en;
  logic                    rd_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= CLR_ON_RST ? StClear : StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign last = (cnt_q == {ADDR_WIDTH{1'b1}});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (CLR) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // Counter wraps to zero on the last word, ready for the next clear.
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    clearing = (state_q == StClear);
    BUSY     = clearing;
    wr_en    = !clearing && !CEN && !GWEN;
    rd_en    = !clearing && !CEN && GWEN;
  end

  // Expand active-low group enables into a per-bit write mask.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      bit_mask[b] = ~WEN[b / GrpW];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clearing) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (wr_en) begin
        mem[A] <= (mem[A] & ~bit_mask) | (D & bit_mask);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[A];
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] q_q;

    // Second stage advances only behind a real read, so idle cycles hold Q.
    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_vld_q <= 1'b0;
        q_q      <= '0;
      end else begin
        rd_vld_q <= rd_en;
        if (rd_vld_q) q_q <= rd_q;
      end
    end

    assign Q = q_q;
  end else begin : g_no_out_reg
    assign Q = rd_q;
  end

endmodule

// File: tb/tb_pa_spsram_clr_param.sv
// Scoreboard bench for pa_spsram_clr_param: default, output-registered and 64/8 byte-mask builds.
module tb_pa_spsram_clr_param;

  localparam logic [42:0] Ones43 = 43'h7FF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        cen;
  logic        gwen;
  logic [42:0] wen;
  logic [7:0]  wen2;
  logic [6:0]  a;
  logic [42:0] d;
  logic [63:0] d2;
  logic [42:0] q0, q1;
  logic [63:0] q2;
  logic        busy0, busy1, busy2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [63:0] sb0[$];
  logic [63:0] sb1[$];
  logic [63:0] sb2[$];

  pa_spsram_clr_param u_dut0 (
    .CLK(clk), .RST(rst), .CLR(clr), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .A(a), .D(d), .Q(q0), .BUSY(busy0)
  );

  pa_spsram_clr_param #(.OUT_REG(1'b1)) u_dut1 (
    .CLK(clk), .RST(rst), .CLR(clr), .CEN(cen), .GWEN(gwen), .WEN(wen),
    .A(a), .D(d), .Q(q1), .BUSY(busy1)
  );

  pa_spsram_clr_param #(.DATA_WIDTH(64), .WE_WIDTH(8), .INIT_VAL(64'h0)) u_dut2 (
    .CLK(clk), .RST(rst), .CLR(clr), .CEN(cen), .GWEN(gwen), .WEN(wen2),
    .A(a), .D(d2), .Q(q2), .BUSY(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c_n, input logic gw_n, input logic [6:0] ad,
                     input logic [63:0] dat, input logic [42:0] m, input logic [7:0] m2,
                     input logic cl);
    cen  = c_n;
    gwen = gw_n;
    a    = ad;
    d    = dat[42:0];
    d2   = dat;
    wen  = m;
    wen2 = m2;
    clr  = cl;
  endtask

  task automatic idle();
    drv(1'b1, 1'b1, 7'd0, 64'd0, '1, '1, 1'b0);
  endtask

  task automatic test_reset();
    logic [6:0]  ra [3];
    logic [63:0] e;
    int          n;
    ra[0] = 7'd0; ra[1] = 7'd64; ra[2] = 7'd127;
    rst = 1'b1;
    idle();
    repeat (3) tick();
    total_cnt++; if ({q0, q1, q2} !== '0) $display("FAIL reset_q got %h %h %h want 0", q0, q1, q2); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL reset_busy got %b want 1", busy0); else pass_cnt++;
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 300) begin tick(); n++; end
    total_cnt++; if (n != 128) $display("FAIL reset_clear_len got %0d want 128", n); else pass_cnt++;
    total_cnt++; if ({busy1, busy2} !== 2'b00) $display("FAIL reset_busy_end got %b%b want 00", busy1, busy2); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b1, ra[i], 64'd0, '1, '1, 1'b0);
      sb0.push_back(64'd0); sb1.push_back(64'd0); sb2.push_back(64'd0);
      tick();
      e = sb0.pop_front();
      total_cnt++; if (q0 !== e[42:0]) $display("FAIL reset_rd0 a=%0d got %h want %h", ra[i], q0, e[42:0]); else pass_cnt++;
      e = sb2.pop_front();
      total_cnt++; if (q2 !== e) $display("FAIL reset_rd2 a=%0d got %h want %h", ra[i], q2, e); else pass_cnt++;
      if (i > 0) begin
        e = sb1.pop_front();
        total_cnt++; if (q1 !== e[42:0]) $display("FAIL reset_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
      end
    end
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL reset_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
  endtask

  task automatic test_write_read();
    logic [63:0] e;
    drv(1'b0, 1'b0, 7'd5, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0, 1'b0);
    tick();
    drv(1'b0, 1'b1, 7'd5, 64'd0, '0, '0, 1'b0);
    sb0.push_back({21'd0, Ones43}); sb1.push_back({21'd0, Ones43});
    sb2.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    e = sb0.pop_front();
    total_cnt++; if (q0 !== e[42:0]) $display("FAIL wr_rd0 got %h want %h", q0, e[42:0]); else pass_cnt++;
    e = sb2.pop_front();
    total_cnt++; if (q2 !== e) $display("FAIL wr_rd2 got %h want %h", q2, e); else pass_cnt++;
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL wr_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
  endtask

  task automatic test_mask();
    logic [63:0] e;
    drv(1'b0, 1'b0, 7'd7, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0, 1'b0);
    tick();
    drv(1'b0, 1'b0, 7'd7, 64'd0, ~43'h1, 8'hFE, 1'b0);
    tick();
    drv(1'b0, 1'b1, 7'd7, 64'd0, '1, '1, 1'b0);
    sb0.push_back(64'h7FF_FFFF_FFFE); sb1.push_back(64'h7FF_FFFF_FFFE);
    sb2.push_back(64'hFFFF_FFFF_FFFF_FF00);
    tick();
    e = sb0.pop_front();
    total_cnt++; if (q0 !== e[42:0]) $display("FAIL mask_rd0 got %h want %h", q0, e[42:0]); else pass_cnt++;
    e = sb2.pop_front();
    total_cnt++; if (q2 !== e) $display("FAIL mask_rd2 got %h want %h", q2, e); else pass_cnt++;
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL mask_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
  endtask

  task automatic test_read_clr();
    logic [63:0] e;
    int          n;
    drv(1'b0, 1'b1, 7'd5, 64'd0, '1, '1, 1'b1);
    sb0.push_back({21'd0, Ones43}); sb1.push_back({21'd0, Ones43});
    sb2.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    e = sb0.pop_front();
    total_cnt++; if (q0 !== e[42:0]) $display("FAIL rdclr_rd0 got %h want %h", q0, e[42:0]); else pass_cnt++;
    e = sb2.pop_front();
    total_cnt++; if (q2 !== e) $display("FAIL rdclr_rd2 got %h want %h", q2, e); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL rdclr_busy got %b want 1", busy0); else pass_cnt++;
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL rdclr_drain1 got %h want %h", q1, e[42:0]); else pass_cnt++;
    n = 1;
    while (busy0 && n < 300) begin tick(); n++; end
    total_cnt++; if (n != 128) $display("FAIL rdclr_len got %0d want 128", n); else pass_cnt++;
    total_cnt++; if ({q0, q1} !== {Ones43, Ones43}) $display("FAIL rdclr_hold got %h %h want %h", q0, q1, Ones43); else pass_cnt++;
  endtask

  task automatic test_clr_write();
    logic [63:0] e;
    logic [6:0]  ra [2];
    int          n;
    ra[0] = 7'd3; ra[1] = 7'd9;
    drv(1'b0, 1'b0, 7'd3, 64'h123, '0, '0, 1'b1);
    tick();
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL clrwr_busy got %b want 1", busy0); else pass_cnt++;
    drv(1'b0, 1'b0, 7'd9, 64'h55, '0, '0, 1'b0);
    n = 0;
    while (busy0 && n < 300) begin
      tick();
      n++;
      if (n == 1) idle();
      if (n == 50) clr = 1'b1;
      if (n == 51) clr = 1'b0;
    end
    total_cnt++; if (n != 128) $display("FAIL clrwr_len got %0d want 128", n); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      drv(1'b0, 1'b1, ra[i], 64'd0, '1, '1, 1'b0);
      sb0.push_back(64'd0); sb1.push_back(64'd0); sb2.push_back(64'd0);
      tick();
      e = sb0.pop_front();
      total_cnt++; if (q0 !== e[42:0]) $display("FAIL clrwr_rd0 a=%0d got %h want %h", ra[i], q0, e[42:0]); else pass_cnt++;
      e = sb2.pop_front();
      total_cnt++; if (q2 !== e) $display("FAIL clrwr_rd2 a=%0d got %h want %h", ra[i], q2, e); else pass_cnt++;
      if (i > 0) begin
        e = sb1.pop_front();
        total_cnt++; if (q1 !== e[42:0]) $display("FAIL clrwr_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
      end
    end
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL clrwr_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
  endtask

  task automatic test_rst_mid_clear();
    logic [63:0] e;
    int          n;
    drv(1'b0, 1'b0, 7'd100, 64'h7_1234_5678, '0, '0, 1'b0);
    tick();
    drv(1'b0, 1'b1, 7'd100, 64'd0, '1, '1, 1'b0);
    sb0.push_back(64'h7_1234_5678); sb1.push_back(64'h7_1234_5678);
    sb2.push_back(64'h7_1234_5678);
    tick();
    e = sb0.pop_front();
    total_cnt++; if (q0 !== e[42:0]) $display("FAIL rstmid_rd0 got %h want %h", q0, e[42:0]); else pass_cnt++;
    e = sb2.pop_front();
    total_cnt++; if (q2 !== e) $display("FAIL rstmid_rd2 got %h want %h", q2, e); else pass_cnt++;
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL rstmid_rd1 got %h want %h", q1, e[42:0]); else pass_cnt++;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (40) tick();
    rst = 1'b1;
    tick();
    total_cnt++; if ({q0, q1, q2} !== '0) $display("FAIL rstmid_q got %h %h %h want 0", q0, q1, q2); else pass_cnt++;
    total_cnt++; if (busy0 !== 1'b1) $display("FAIL rstmid_busy got %b want 1", busy0); else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++; if ({q0, q1, q2} !== '0) $display("FAIL rstmid_q_after got %h %h %h want 0", q0, q1, q2); else pass_cnt++;
    n = 1;
    while (busy0 && n < 300) begin tick(); n++; end
    total_cnt++; if (n != 128) $display("FAIL rstmid_len got %0d want 128", n); else pass_cnt++;
    drv(1'b0, 1'b1, 7'd100, 64'd0, '1, '1, 1'b0);
    sb0.push_back(64'd0); sb1.push_back(64'd0); sb2.push_back(64'd0);
    tick();
    e = sb0.pop_front();
    total_cnt++; if (q0 !== e[42:0]) $display("FAIL rstmid_rd0b got %h want %h", q0, e[42:0]); else pass_cnt++;
    e = sb2.pop_front();
    total_cnt++; if (q2 !== e) $display("FAIL rstmid_rd2b got %h want %h", q2, e); else pass_cnt++;
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL rstmid_rd1b got %h want %h", q1, e[42:0]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 7'(i + 1), 64'(10 + i), '0, '0, 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b1, 7'(i + 1), 64'd0, '1, '1, 1'b0);
      sb0.push_back(64'(10 + i)); sb1.push_back(64'(10 + i)); sb2.push_back(64'(10 + i));
      tick();
      e = sb0.pop_front();
      total_cnt++; if (q0 !== e[42:0]) $display("FAIL b2b_rd0 i=%0d got %h want %h", i, q0, e[42:0]); else pass_cnt++;
      e = sb2.pop_front();
      total_cnt++; if (q2 !== e) $display("FAIL b2b_rd2 i=%0d got %h want %h", i, q2, e); else pass_cnt++;
      if (i > 0) begin
        e = sb1.pop_front();
        total_cnt++; if (q1 !== e[42:0]) $display("FAIL b2b_rd1 i=%0d got %h want %h", i, q1, e[42:0]); else pass_cnt++;
      end
    end
    idle();
    tick();
    e = sb1.pop_front();
    total_cnt++; if (q1 !== e[42:0]) $display("FAIL b2b_rd1 last got %h want %h", q1, e[42:0]); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if ({q0, q1} !== {43'hC, 43'hC}) $display("FAIL b2b_hold got %h %h want c c", q0, q1); else pass_cnt++;
    total_cnt++; if (sb0.size() + sb1.size() + sb2.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb0.size() + sb1.size() + sb2.size()); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_write_read();
    test_mask();
    test_read_clr();
    test_clr_write();
    test_rst_mid_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pa_spsram_clr_param.md
# pa_spsram_clr_param

Parametrised single-port SRAM wrapper for IFU/LSU tag and data arrays. It supersedes the fixed-geometry per-array wrappers and keeps their active-low CEN/GWEN/WEN macro protocol. On top of that protocol it adds three things:
- a built-in hardware clear engine that initialises every word after reset or on request, with a BUSY indication;
- configurable write-mask granularity;
- an optional output register stage.

The storage is a synthesizable array, so the block serves as the FPGA memory model for any depth and width.

## Interface
Parameters:
- ADDR_WIDTH, 7, address bits; depth = 2^ADDR_WIDTH words
- DATA_WIDTH, 43, word width
- WE_WIDTH, 43, number of write-enable groups; must divide DATA_WIDTH; group size G = DATA_WIDTH/WE_WIDTH
- INIT_VAL, 0, DATA_WIDTH-bit value written by the clear engine
- CLR_ON_RST, 1, 1 = clear runs automatically when reset is released
- OUT_REG, 0, 1 = extra output register; read latency becomes 2

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- CLR  in  1  clear request, single-cycle pulse, sampled when idle
- CEN  in  1  chip enable, active low
- GWEN  in  1  global write enable, active low (0 = write, 1 = read)
- WEN  in  WE_WIDTH  per-group write enable, active low
- A  in  ADDR_WIDTH  word address
- D  in  DATA_WIDTH  write data
- Q  out  DATA_WIDTH  read data
- BUSY  out  1  clear engine active; external accesses are ignored

## Operation
- States:
  - IDLE: normal access.
  - CLEAR: clear counter cnt walks 0..depth-1, writing INIT_VAL to word cnt each cycle.
- Reset (RST=1):
  - state = CLEAR with cnt = 0 if CLR_ON_RST=1, else IDLE.
  - Q = 0; output pipeline registers = 0.
  - No array writes occur while RST=1.
- CLEAR → IDLE: on the edge that writes word depth-1 (cnt == depth-1); cnt then returns to 0.
- IDLE → CLEAR: on the edge where CLR=1. Any external access in that same cycle is still performed first.
- CLR while in CLEAR: ignored; the clear in progress is not restarted.
- BUSY = (state == CLEAR); driven combinationally from the state register.
- Write, IDLE only (CEN=0, GWEN=0): for each i with WEN[i]=0, mem[A][i*G +: G] ← D[i*G +: G]; other groups unchanged. Q holds its value.
- Read, IDLE only (CEN=0, GWEN=1): returns mem[A] as held before this edge. WEN is ignored.
- CEN=1, or any access while BUSY=1: no array effect, and Q holds.
- Address arithmetic: cnt is ADDR_WIDTH bits wide; the last-word compare uses all ones. No wrap beyond depth.
- RST asserted mid-clear: the clear aborts immediately. It restarts from word 0 after release if CLR_ON_RST=1. Otherwise the array contents are undefined and software must issue CLR.

## Timing
- OUT_REG=0: read accepted at edge N → Q valid after edge N, stable until the next accepted read.
- OUT_REG=1: read data is captured into an internal register at edge N and appears on Q after edge N+1.
  - Back-to-back reads are fully pipelined at one read per cycle.
  - The second stage updates only when the first stage held a valid read.
- Read-after-write to the same address in consecutive cycles returns the new data (array already updated).
- Clear duration: exactly depth cycles of BUSY=1 from the first edge with RST=0 (or from the edge after CLR is sampled). Default depth gives 128 cycles.
- The first access accepted after a clear is the one presented in the first cycle with BUSY=0.
- Simultaneous read and CLR in IDLE: the read completes normally, including the OUT_REG pipeline drain during CLEAR. Q then holds through the clear.

## Test plan
- Reset with defaults, RST high 3 cycles then low → BUSY=1 for exactly 128 cycles. Afterwards, reads of addresses 0, 64 and 127 return 0.
- Write D=43'h7FF_FFFF_FFFF with WEN all 0 at A=5, then read A=5 → Q=43'h7FF_FFFF_FFFF one cycle after the read edge (two cycles with OUT_REG=1).
- With WE_WIDTH=43: write all ones, then write D=0 with WEN=~43'h1 at the same address, then read → Q=43'h7FF_FFFF_FFFE. Repeat with DATA_WIDTH=64, WE_WIDTH=8, byte mask 8'hFE → only byte 0 cleared.
- Issue CLR together with a write of 0x123 to A=3 in the same cycle → write lands, then BUSY=1 for 128 cycles. Read A=3 afterwards → INIT_VAL. A write attempted while BUSY=1 is dropped.
- Assert RST at cnt=40 mid-clear, hold 1 cycle, release → BUSY restarts a full 128-cycle clear from word 0. Q=0 during and just after reset.
- OUT_REG=1: back-to-back reads of A=1,2,3 holding 0xA, 0xB, 0xC → Q sequence 0xA, 0xB, 0xC on consecutive cycles starting two edges after the first read. Idle cycles afterwards hold 0xC.
